exec_seq_ctrl: RTL and testbench

- Sequences multi-cycle operations in the execute stage: integer MULT/DIV, the pipelined FPU units (add, sub, mul, inv, sqrt), loads through the 1-cycle-registered BRAM port, and UART IN/OUT.
- Decodes the issued op into a per-unit latency, holds a pipeline stall until the result is valid, then pulses done.
- Merges the UART engine's busy so the pipeline sees one stall.

---
 rtl/exec_seq_ctrl_if.sv | 26 ++
 rtl/exec_seq_ctrl.sv | 117 +++++++++++
 tb/tb_exec_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_seq_ctrl_if.sv
// exec_seq_ctrl_if: issue/stall handshake between the pipeline and exec_seq_ctrl.
// EXEC_SEQ_PERF_EN adds the stall_cycles/op_count counters to the bundle.
interface exec_seq_ctrl_if;
  logic       start;
  logic [1:0] op_type;
  logic [5:0] instr;
  logic       flush;
  logic       uart_busy;
  logic       stall;
  logic       done;
  logic [2:0] unit;
  logic       issue_err;
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] op_count;
  modport master (output start, op_type, instr, flush, uart_busy,
                  input stall, done, unit, issue_err, stall_cycles, op_count);
  modport slave  (input start, op_type, instr, flush, uart_busy,
                  output stall, done, unit, issue_err, stall_cycles, op_count);
`else
  modport master (output start, op_type, instr, flush, uart_busy,
                  input stall, done, unit, issue_err);
  modport slave  (input start, op_type, instr, flush, uart_busy,
                  output stall, done, unit, issue_err);
`endif
endinterface

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: execute-stage sequencer for multi-cycle units (mul/div/fpu/mem/uart).
// EXEC_SEQ_PERF_EN adds saturating stall_cycles and op_count outputs.
module exec_seq_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_LAT   = 36,
  parameter int FADD_LAT  = 3,
  parameter int FMUL_LAT  = 2,
  parameter int FINV_LAT  = 4,
  parameter int FSQRT_LAT = 4,
  parameter int LW_LAT    = 2,
  parameter int CNT_W     = 6
) (
  input logic            clk,
  input logic            rst,
  exec_seq_ctrl_if.slave bus
);
  localparam logic [1:0] OPT_I = 2'b00, OPT_R = 2'b01, OPT_F = 2'b10;
  localparam logic [5:0] FUNC_MULT = 6'h18, FUNC_DIV = 6'h1a;
  localparam logic [5:0] OP_LW = 6'h23, OP_LW_S = 6'h31, OP_IN = 6'h1c, OP_OUT = 6'h1d;
  localparam logic [5:0] FPU_ADD = 6'h00, FPU_SUB = 6'h01, FPU_MUL = 6'h02;
  localparam logic [5:0] FPU_INV = 6'h03, FPU_SQRT = 6'h04;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, UART} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic [2:0]       unit_q, unit_d, dec_unit;
  logic             err_q, err_d, multi, uart_op, accept, seq;
  always_comb begin
    dec_unit = 3'd0;
    lat      = '0;
    case ({bus.op_type, bus.instr})
      {OPT_R, FUNC_MULT}: begin dec_unit = 3'd1; lat = CNT_W'(MUL_LAT);   end
      {OPT_R, FUNC_DIV}:  begin dec_unit = 3'd2; lat = CNT_W'(DIV_LAT);   end
      {OPT_F, FPU_ADD},
      {OPT_F, FPU_SUB}:   begin dec_unit = 3'd3; lat = CNT_W'(FADD_LAT);  end
      {OPT_F, FPU_MUL}:   begin dec_unit = 3'd3; lat = CNT_W'(FMUL_LAT);  end
      {OPT_F, FPU_INV}:   begin dec_unit = 3'd3; lat = CNT_W'(FINV_LAT);  end
      {OPT_F, FPU_SQRT}:  begin dec_unit = 3'd3; lat = CNT_W'(FSQRT_LAT); end
      {OPT_I, OP_LW},
      {OPT_I, OP_LW_S}:   begin dec_unit = 3'd4; lat = CNT_W'(LW_LAT);    end
      {OPT_I, OP_IN},
      {OPT_I, OP_OUT}:    dec_unit = 3'd5;
      default:            dec_unit = 3'd0;
    endcase
  end
  // Latencies of 0 or 1 complete in the issue cycle and never enter the sequencer.
  assign multi   = (dec_unit >= 3'd1) && (dec_unit <= 3'd4) && (lat >= TWO);
  assign uart_op = dec_unit == 3'd5;
  assign accept  = bus.start && !bus.flush && (state_q == IDLE);
  assign seq     = accept && (multi || uart_op);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    unit_d    = unit_q;
    err_d     = err_q | (bus.start & ~bus.flush & (state_q != IDLE));
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall = seq;
        unit_d    = seq ? dec_unit : 3'd0;
        cnt_d     = (seq && multi) ? lat - ONE : '0;
        state_d   = !seq ? IDLE : uart_op ? UART : (cnt_d <= ONE) ? DONE : WAIT;
      end
      WAIT: begin
        bus.stall = 1'b1;
        cnt_d     = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
        state_d   = (cnt_d <= ONE) ? DONE : WAIT;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
        unit_d   = 3'd0;
        cnt_d    = '0;
      end
      UART: begin
        bus.stall = 1'b1;
        state_d   = bus.uart_busy ? UART : DONE;
      end
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      unit_d  = 3'd0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      unit_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      err_q   <= err_d;
    end
  end
  assign bus.unit      = unit_q;
  assign bus.issue_err = err_q;
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_cycles_q, op_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      op_count_q     <= '0;
    end else begin
      if (bus.stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (accept && op_count_q != '1) op_count_q <= op_count_q + 32'd1;
    end
  end
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.op_count     = op_count_q;
`endif
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// tb_exec_seq_ctrl: directed and random checks of exec_seq_ctrl against a cycle-indexed model.
module tb_exec_seq_ctrl;
  localparam logic [1:0] TI = 2'b00, TR = 2'b01, TF = 2'b10;
  localparam logic [5:0] MULT = 6'h18, DIV = 6'h1a, ADD = 6'h20, LW = 6'h23, LWS = 6'h31;
  localparam logic [5:0] IN = 6'h1c, OUT = 6'h1d, FADD = 6'h00, FSUB = 6'h01, FMUL = 6'h02;
  localparam logic [5:0] FINV = 6'h03, FSQRT = 6'h04;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0;
  logic rst;
  exec_seq_ctrl_if bus();
  exec_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  bit m_act, m_err, m_uart;
  int m_done_at, issue_cyc;
  int m_unit;
  longint m_stalls, m_ops;
  int st_cnt, n_done, done_cyc, done_unit;
  logic [7:0] ops [14] = '{{TR, MULT}, {TR, DIV}, {TR, ADD}, {TF, FADD}, {TF, FSUB},
                           {TF, FMUL}, {TF, FINV}, {TF, FSQRT}, {TI, LW}, {TI, LWS},
                           {TI, IN}, {TI, OUT}, {TI, 6'h08}, {TF, 6'h10}};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void dec(input logic [7:0] k, output int u, output int l);
    u = 0;
    l = 0;
    case (k)
      {TR, MULT}:              begin u = 1; l = 2;  end
      {TR, DIV}:               begin u = 2; l = 36; end
      {TF, FADD}, {TF, FSUB}:  begin u = 3; l = 3;  end
      {TF, FMUL}:              begin u = 3; l = 2;  end
      {TF, FINV}, {TF, FSQRT}: begin u = 3; l = 4;  end
      {TI, LW}, {TI, LWS}:     begin u = 4; l = 2;  end
      {TI, IN}, {TI, OUT}:     u = 5;
      default:                 u = 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_act = 0; m_err = 0; m_uart = 0; m_done_at = BIG; m_unit = 0;
    m_stalls = 0; m_ops = 0;
  endfunction

  function automatic void clear_obs();
    st_cnt = 0; n_done = 0; done_cyc = -1; done_unit = -1;
  endfunction

  task automatic step(input bit s, input logic [1:0] t, input logic [5:0] i,
                      input bit f, input bit b);
    int u, l;
    bit es, ed;
    @(negedge clk);
    bus.start = s; bus.op_type = t; bus.instr = i; bus.flush = f; bus.uart_busy = b;
    #2;
    dec({t, i}, u, l);
    ed = m_act && (cyc == m_done_at);
    es = m_act ? !ed : (s && !f && ((u >= 1 && u <= 4 && l >= 2) || u == 5));
    chk("stall", bus.stall, es);
    chk("done", bus.done, ed);
    chk("unit", bus.unit, m_act ? m_unit : 0);
    chk("issue_err", bus.issue_err, m_err);
`ifdef EXEC_SEQ_PERF_EN
    chk("stall_cycles", bus.stall_cycles, m_stalls);
    chk("op_count", bus.op_count, m_ops);
`endif
    if (bus.stall) st_cnt++;
    if (bus.done) begin n_done++; done_cyc = cyc - issue_cyc; done_unit = bus.unit; end
    if (es) m_stalls++;
    if (f) m_act = 0;
    else if (m_act) begin
      if (s) m_err = 1;
      if (ed) m_act = 0;
      else if (m_uart && !b && m_done_at == BIG) m_done_at = cyc + 1;
    end else if (s) begin
      m_ops++;
      issue_cyc = cyc;
      if (u >= 1 && u <= 4 && l >= 2) begin
        m_act = 1; m_uart = 0; m_unit = u; m_done_at = cyc + l - 1;
      end else if (u == 5) begin
        m_act = 1; m_uart = 1; m_unit = 5; m_done_at = BIG;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit b);
    for (int k = 0; k < n; k++) step(0, TR, ADD, 0, b);
  endtask

  initial begin
    bit s, f, ub;
    logic [7:0] op;
    longint sc0;
    rst = 1;
    bus.start = 0; bus.op_type = 0; bus.instr = 0; bus.flush = 0; bus.uart_busy = 0;
    model_reset();
    clear_obs();
    issue_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_unit", bus.unit, 0);
    chk("rst_issue_err", bus.issue_err, 0);
    @(negedge clk);
    rst = 0;
    // MULT: only the issue cycle stalls, done one cycle later
    clear_obs();
    step(1, TR, MULT, 0, 0);
    idle(3, 0);
    chk("mult_stalls", st_cnt, 1);
    chk("mult_done_at", done_cyc, 1);
    chk("mult_done_unit", done_unit, 1);
    chk("mult_done_cnt", n_done, 1);
    // DIV: 35 stall cycles, done at +35
    clear_obs();
`ifdef EXEC_SEQ_PERF_EN
    sc0 = bus.stall_cycles;
`else
    sc0 = 0;
`endif
    step(1, TR, DIV, 0, 0);
    idle(38, 0);
    chk("div_stalls", st_cnt, 35);
    chk("div_done_at", done_cyc, 35);
    chk("div_done_unit", done_unit, 2);
`ifdef EXEC_SEQ_PERF_EN
    chk("div_perf_stalls", bus.stall_cycles - sc0, 35);
`endif
    // OP_OUT with uart_busy high for ten cycles
    clear_obs();
    step(1, TI, OUT, 0, 1);
    idle(9, 1);
    idle(4, 0);
    chk("uart_stalls", st_cnt, 11);
    chk("uart_done_at", done_cyc, 11);
    chk("uart_done_unit", done_unit, 5);
    // FPU_SQRT flushed at +2
    clear_obs();
    step(1, TF, FSQRT, 0, 0);
    idle(1, 0);
    step(0, TR, ADD, 1, 0);
    idle(4, 0);
    chk("flush_stalls", st_cnt, 3);
    chk("flush_no_done", n_done, 0);
    // flush in the issue cycle drops the start
    clear_obs();
    step(1, TR, DIV, 1, 0);
    idle(2, 0);
    chk("flush_issue_stalls", st_cnt, 0);
    // FPU_ADD with a second start at +1
    clear_obs();
    chk("err_before", bus.issue_err, 0);
    step(1, TF, FADD, 0, 0);
    step(1, TF, FADD, 0, 0);
    idle(4, 0);
    chk("dbl_stalls", st_cnt, 2);
    chk("dbl_done_at", done_cyc, 2);
    chk("dbl_done_cnt", n_done, 1);
    chk("dbl_issue_err", bus.issue_err, 1);
    // LW and a single-cycle op
    clear_obs();
    step(1, TI, LW, 0, 0);
    step(1, TR, ADD, 0, 0);
    idle(2, 0);
    chk("lw_stalls", st_cnt, 1);
    chk("lw_done_cnt", n_done, 1);
    // randomized traffic
    ub = 0;
    for (int n = 0; n < 3000; n++) begin
      s = $urandom_range(0, 2) == 0;
      f = $urandom_range(0, 29) == 0;
      if (f && m_act) s = 0;
      if ($urandom_range(0, 4) == 0) ub = ~ub;
      op = ops[$urandom_range(0, 13)];
      step(s, op[7:6], op[5:0], f, ub);
    end
    // asynchronous reset at +5 of a DIV
    idle(1, 0);
    step(0, TR, ADD, 1, 0);
    step(1, TR, DIV, 0, 0);
    idle(4, 0);
    @(negedge clk);
    bus.start = 0; bus.flush = 0; bus.uart_busy = 0;
    #2;
    chk("pre_rst_unit", bus.unit, 2);
    chk("pre_rst_stall", bus.stall, 1);
    rst = 1;
    #1;
    chk("arst_stall", bus.stall, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_unit", bus.unit, 0);
    chk("arst_issue_err", bus.issue_err, 0);
`ifdef EXEC_SEQ_PERF_EN
    chk("arst_stall_cycles", bus.stall_cycles, 0);
    chk("arst_op_count", bus.op_count, 0);
`endif
    model_reset();
    cyc++;
    @(negedge clk);
    rst = 0;
    clear_obs();
    step(1, TR, ADD, 0, 0);
    idle(3, 0);
    chk("post_rst_stalls", st_cnt, 0);
    chk("post_rst_done", n_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
